// File: rtl/accum_readout_if.sv
// Processor read bus of the correlator accumulator readout block.
// Handshake: a read is requested by holding rd_en high for one clk cycle with
// rd_addr valid in that same cycle; there is no ready/back-pressure, so every
// sampled rd_en is accepted and answered by rd_valid high for exactly one cycle
// on the following edge, with rd_data valid while rd_valid is high.
// new_data/overrun are level status flags that are always valid.
interface accum_readout_if #(
    parameter int ACC_W = 16
);
    logic             rd_en;
    logic [2:0]       rd_addr;
    logic [ACC_W-1:0] rd_data;
    logic             rd_valid;
    logic             new_data;
    logic             overrun;

    // Processor side
    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        input  rd_valid,
        input  new_data,
        input  overrun
    );

    // Readout block side
    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        output rd_valid,
        output new_data,
        output overrun
    );
endinterface

// File: rtl/accum_readout.sv
// Accumulator readout: captures the six latched I/Q early/prompt/late
// accumulations one cycle after each dump pulse, counts captures, tracks
// unread/overrun status and serves register reads to the processor.
// No FSM: capture and read paths are independent single-cycle datapaths.
module accum_readout #(
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    dump_enable,
    input  logic signed [ACC_W-1:0] i_early,
    input  logic signed [ACC_W-1:0] i_prompt,
    input  logic signed [ACC_W-1:0] i_late,
    input  logic signed [ACC_W-1:0] q_early,
    input  logic signed [ACC_W-1:0] q_prompt,
    input  logic signed [ACC_W-1:0] q_late,
    accum_readout_if.slave          rd_bus
);

    // Address map of the read bus
    localparam logic [2:0] ADDR_I_EARLY  = 3'd0;
    localparam logic [2:0] ADDR_I_PROMPT = 3'd1;
    localparam logic [2:0] ADDR_I_LATE   = 3'd2;
    localparam logic [2:0] ADDR_Q_EARLY  = 3'd3;
    localparam logic [2:0] ADDR_Q_PROMPT = 3'd4;
    localparam logic [2:0] ADDR_Q_LATE   = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;
    localparam logic [2:0] ADDR_COUNT    = 3'd7;

    logic             dump_d1_q;
    logic [ACC_W-1:0] hold_q [6];
    logic [ACC_W-1:0] hold_d [6];
    logic [15:0]      dump_count_q, dump_count_d;
    logic             new_data_q, new_data_d;
    logic             overrun_q, overrun_d;
    logic [ACC_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q;

    logic             capture;
    logic             status_rd;
    logic [ACC_W-1:0] count_ext;
    logic [ACC_W-1:0] status_word;

    // The accumulators publish their latched value one cycle after the dump
    // pulse, so the capture strobe is the registered dump pulse.
    assign capture     = dump_d1_q;
    assign status_rd   = rd_bus.rd_en && (rd_bus.rd_addr == ADDR_STATUS);
    assign status_word = {{(ACC_W-2){1'b0}}, overrun_q, new_data_q};

    // The 16-bit capture counter is presented zero-extended or truncated
    // to the read-bus width.
    generate
        if (ACC_W == 16) begin : g_cnt_eq
            assign count_ext = dump_count_q;
        end else if (ACC_W > 16) begin : g_cnt_wide
            assign count_ext = {{(ACC_W-16){1'b0}}, dump_count_q};
        end else begin : g_cnt_narrow
            assign count_ext = dump_count_q[ACC_W-1:0];
        end
    endgenerate

    // Capture path: all six holding registers load together, counter advances.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            hold_d[k] = hold_q[k];
        end
        dump_count_d = dump_count_q;
        if (capture) begin
            hold_d[0]    = i_early;
            hold_d[1]    = i_prompt;
            hold_d[2]    = i_late;
            hold_d[3]    = q_early;
            hold_d[4]    = q_prompt;
            hold_d[5]    = q_late;
            dump_count_d = dump_count_q + 16'd1;
        end
    end

    // Status flags: a capture always marks data as unread; a status read
    // clears both flags, but a capture on the same edge re-arms new_data and
    // does not count as an overrun because the status read consumed the old one.
    always_comb begin
        new_data_d = new_data_q;
        overrun_d  = overrun_q;
        if (capture) begin
            new_data_d = 1'b1;
        end else if (status_rd) begin
            new_data_d = 1'b0;
        end
        if (status_rd) begin
            overrun_d = 1'b0;
        end else if (capture && new_data_q) begin
            overrun_d = 1'b1;
        end
    end

    // Read mux selects pre-edge register contents; rd_data holds when idle.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_bus.rd_en) begin
            case (rd_bus.rd_addr)
                ADDR_I_EARLY:  rd_data_d = hold_q[0];
                ADDR_I_PROMPT: rd_data_d = hold_q[1];
                ADDR_I_LATE:   rd_data_d = hold_q[2];
                ADDR_Q_EARLY:  rd_data_d = hold_q[3];
                ADDR_Q_PROMPT: rd_data_d = hold_q[4];
                ADDR_Q_LATE:   rd_data_d = hold_q[5];
                ADDR_STATUS:   rd_data_d = status_word;
                ADDR_COUNT:    rd_data_d = count_ext;
                default:       rd_data_d = rd_data_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset; reset also drops
    // any dump pulse pending in dump_d1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dump_d1_q    <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                hold_q[k] <= '0;
            end
            dump_count_q <= '0;
            new_data_q   <= 1'b0;
            overrun_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            dump_d1_q    <= dump_enable;
            for (int k = 0; k < 6; k++) begin
                hold_q[k] <= hold_d[k];
            end
            dump_count_q <= dump_count_d;
            new_data_q   <= new_data_d;
            overrun_q    <= overrun_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_bus.rd_en;
        end
    end

    assign rd_bus.rd_data  = rd_data_q;
    assign rd_bus.rd_valid = rd_valid_q;
    assign rd_bus.new_data = new_data_q;
    assign rd_bus.overrun  = overrun_q;

endmodule
